wb_alu_seq: RTL and testbench



---
 rtl/wb_alu_seq.sv | 158 +++++++++++++++
 tb/tb_wb_alu_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_alu_seq.sv
// Wishbone ALU peripheral: operand/control registers, single-cycle ALU ops and a
// WIDTH-cycle shift-add multiplier producing a 2*WIDTH-bit result.
module wb_alu_seq #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          WIDTH        = 32,
    parameter int          NUM_LEDS     = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [31:0]         i_wb_addr,
    input  logic [31:0]         i_wb_data,
    output logic                o_wb_ack,
    output logic                o_wb_stall,
    output logic [31:0]         o_wb_data,
    input  logic                buttons,
    output logic                irq,
    output logic [NUM_LEDS-1:0] leds,
    output logic [NUM_LEDS-1:0] led_enb
);

    localparam int SW = $clog2(2*WIDTH);
    localparam int CW = $clog2(WIDTH+1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W = '0;

    logic [1:0]         state;
    logic [WIDTH-1:0]   opa, opb, mplier;
    logic [4:0]         ctrl;
    logic [2*WIDTH-1:0] result, mcand, acc, acc_nxt;
    logic [CW-1:0]      cnt;
    logic               done, err, ovr, busy;
    logic [31:0]        offset, rd_data, led_full;
    logic [2:0]         word;
    logic               mapped, req, wr, rd, op_wr;

    function automatic logic [2*WIDTH-1:0] alu_op(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ax, bx;
        ax = {ZERO_W, a};
        bx = {ZERO_W, b};
        case (op)
            4'd0:    return {ZERO_W, ~a};
            4'd1:    return {ZERO_W, a & b};
            4'd2:    return ax;
            4'd3:    return {ZERO_W, a | b};
            4'd4:    return {ZERO_W, a - ONE_W};
            4'd5:    return ax + bx;
            4'd6:    return {ZERO_W, a - b};
            4'd7:    return ax + ONE_2W;
            4'd9:    return {ZERO_W, a ^ b};
            4'd10:   return ax << b[SW-1:0];
            4'd11:   return ax >> b[SW-1:0];
            default: return '0;
        endcase
    endfunction

    assign offset = i_wb_addr - BASE_ADDRESS;
    assign word   = offset[4:2];
    assign mapped = (offset[31:5] == 27'd0) && (offset[1:0] == 2'b00) && (word <= 3'd5);
    assign req    = i_wb_cyc & i_wb_stb & mapped;
    assign wr     = req & i_wb_we;
    assign rd     = req & ~i_wb_we;
    assign op_wr  = wr && (word == 3'd0 || word == 3'd3 || word == 3'd4);
    assign busy   = (state != S_IDLE);

    assign acc_nxt = mplier[0] ? acc + mcand : acc;

    always_comb begin
        rd_data = '0;
        case (word)
            3'd0:    rd_data[WIDTH-1:0] = opa;
            3'd1:    rd_data[4:0]       = {ovr, err, buttons, done, busy};
            3'd2:    rd_data[WIDTH-1:0] = result[WIDTH-1:0];
            3'd3:    rd_data[WIDTH-1:0] = opb;
            3'd4:    rd_data[4:0]       = ctrl;
            3'd5:    rd_data[WIDTH-1:0] = result[2*WIDTH-1:WIDTH];
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            opa       <= '0;
            opb       <= '0;
            ctrl      <= '0;
            result    <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovr       <= 1'b0;
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack  <= req;
            o_wb_data <= rd ? rd_data : 32'd0;
            if (wr && !busy && word == 3'd0) opa <= i_wb_data[WIDTH-1:0];
            if (wr && !busy && word == 3'd3) opb <= i_wb_data[WIDTH-1:0];
            if (wr && word == 3'd1) begin
                if (i_wb_data[1]) done <= 1'b0;
                if (i_wb_data[3]) err  <= 1'b0;
                if (i_wb_data[4]) ovr  <= 1'b0;
            end
            if (op_wr && busy) ovr <= 1'b1;
            // Completion updates come last so a same-edge done clear loses.
            case (state)
                S_IDLE: begin
                    if (wr && word == 3'd4) begin
                        ctrl   <= i_wb_data[4:0];
                        done   <= 1'b0;
                        mcand  <= {ZERO_W, opa};
                        mplier <= opb;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH);
                        state  <= (i_wb_data[3:0] == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result <= alu_op(ctrl[3:0], mcand[WIDTH-1:0], mplier);
                    if (ctrl[3:2] == 2'b11) err <= 1'b1;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result <= acc_nxt;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign led_full   = {20'd0, ctrl[3:0], result[3:0], opa[3:0]};
    assign leds       = led_full[NUM_LEDS-1:0];
    assign led_enb    = '0;
    assign o_wb_stall = 1'b0;
    assign irq        = done & ctrl[4];

endmodule

// File: tb/tb_wb_alu_seq.sv
// Directed bench for wb_alu_seq: bus reads queue their expected data and are
// compared when the acknowledge returns.
module tb_wb_alu_seq;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_OPA  = BASE + 32'd0;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_RLO  = BASE + 32'd8;
    localparam logic [31:0] A_OPB  = BASE + 32'd12;
    localparam logic [31:0] A_CTRL = BASE + 32'd16;
    localparam logic [31:0] A_RHI  = BASE + 32'd20;

    logic        clk, reset;
    logic        cyc, stb, we;
    logic [31:0] addr, wdata;
    logic        ack, stall;
    logic [31:0] rdata;
    logic        buttons, irq;
    logic [11:0] leds, led_enb;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    wb_alu_seq #(.BASE_ADDRESS(BASE), .WIDTH(32), .NUM_LEDS(12)) dut (
        .clk(clk), .reset(reset),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata),
        .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdata),
        .buttons(buttons), .irq(irq), .leds(leds), .led_enb(led_enb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] st(input logic b, input logic d, input logic e, input logic o);
        return {27'd0, o, e, buttons, d, b};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        check({tag, "_ack"}, {31'd0, ack}, 32'd1);
        e = sb_q.pop_front();
        check(e.tag, rdata, e.exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; buttons = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_leds", {20'd0, leds}, 32'd0);
        check("rst_led_enb", {20'd0, led_enb}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        bus_read(A_OPA, 32'd0, "rst_opa");
        bus_read(A_STAT, st(0, 0, 0, 0), "rst_status");
        bus_read(A_RLO, 32'd0, "rst_reslo");
        bus_read(A_OPB, 32'd0, "rst_opb");
        bus_read(A_CTRL, 32'd0, "rst_ctrl");
        bus_read(A_RHI, 32'd0, "rst_reshi");

        // Unmapped address is never acknowledged
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = BASE + 32'd24;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        check("unmapped_ack", {31'd0, ack}, 32'd0);

        buttons = 1'b0;
        // Add with carry into the upper half
        bus_write(A_OPA, 32'hFFFF_FFFF, "add_opa");
        bus_write(A_OPB, 32'd1, "add_opb");
        bus_write(A_CTRL, 32'd5, "add_ctrl");
        bus_read(A_STAT, st(1, 0, 0, 0), "add_status_e1");
        bus_read(A_STAT, st(0, 1, 0, 0), "add_status_e2");
        bus_read(A_RLO, 32'd0, "add_reslo");
        bus_read(A_RHI, 32'd1, "add_reshi");
        check("add_irq_off", {31'd0, irq}, 32'd0);

        // Full-width multiply with irq, writes during busy are ignored
        bus_write(A_OPB, 32'hFFFF_FFFF, "mul_opb");
        bus_write(A_CTRL, 32'h18, "mul_ctrl");
        bus_write(A_OPA, 32'd5, "mul_busy_opa");
        bus_write(A_CTRL, 32'd1, "mul_busy_ctrl");
        bus_read(A_STAT, st(1, 0, 0, 1), "mul_status_e3");
        idle(28);
        bus_read(A_STAT, st(1, 0, 0, 1), "mul_status_e32");
        bus_read(A_STAT, st(0, 1, 0, 1), "mul_status_e33");
        check("mul_irq_on", {31'd0, irq}, 32'd1);
        bus_read(A_RHI, 32'hFFFF_FFFE, "mul_reshi");
        bus_read(A_RLO, 32'h0000_0001, "mul_reslo");
        bus_read(A_OPA, 32'hFFFF_FFFF, "mul_opa_kept");
        bus_read(A_CTRL, 32'h18, "mul_ctrl_kept");
        bus_write(A_STAT, 32'h12, "mul_clear");
        check("mul_irq_off", {31'd0, irq}, 32'd0);
        bus_read(A_STAT, st(0, 0, 0, 0), "mul_status_clr");

        // Shifts
        bus_write(A_OPA, 32'd1, "shl_opa");
        bus_write(A_OPB, 32'd40, "shl_opb");
        bus_write(A_CTRL, 32'd10, "shl_ctrl");
        idle(1);
        bus_read(A_RHI, 32'h100, "shl_reshi");
        bus_read(A_RLO, 32'd0, "shl_reslo");
        bus_write(A_OPA, 32'h8000_0000, "shr_opa");
        bus_write(A_OPB, 32'd4, "shr_opb");
        bus_write(A_CTRL, 32'd11, "shr_ctrl");
        idle(1);
        bus_read(A_RLO, 32'h0800_0000, "shr_reslo");
        bus_read(A_RHI, 32'd0, "shr_reshi");

        // Subtract wraps
        bus_write(A_OPA, 32'd0, "sub_opa");
        bus_write(A_OPB, 32'd1, "sub_opb");
        bus_write(A_CTRL, 32'd6, "sub_ctrl");
        idle(1);
        bus_read(A_RLO, 32'hFFFF_FFFF, "sub_reslo");
        bus_read(A_RHI, 32'd0, "sub_reshi");

        // Illegal opcode
        bus_write(A_CTRL, 32'd13, "ill_ctrl");
        idle(1);
        bus_read(A_STAT, st(0, 1, 1, 0), "ill_status");
        bus_read(A_RLO, 32'd0, "ill_reslo");
        bus_read(A_RHI, 32'd0, "ill_reshi");
        bus_write(A_STAT, 32'h8, "ill_clear");
        bus_read(A_STAT, st(0, 1, 0, 0), "ill_status_clr");

        // CTRL write on the completion edge is ignored
        bus_write(A_OPA, 32'h0F0F, "col_opa");
        bus_write(A_OPB, 32'h00FF, "col_opb");
        bus_write(A_CTRL, 32'd9, "col_ctrl");
        bus_write(A_CTRL, 32'd0, "col_ctrl_late");
        bus_read(A_STAT, st(0, 1, 0, 1), "col_status");
        bus_read(A_RLO, 32'h0FF0, "col_reslo");
        bus_read(A_CTRL, 32'd9, "col_ctrl_kept");
        bus_write(A_STAT, 32'h10, "col_clear");

        // done set beats a same-edge write-1-to-clear
        bus_write(A_CTRL, 32'd2, "setwin_ctrl");
        bus_write(A_STAT, 32'h2, "setwin_clear");
        bus_read(A_STAT, st(0, 1, 0, 0), "setwin_status");
        bus_read(A_RLO, 32'h0F0F, "setwin_reslo");

        // Reset during multiply aborts it
        buttons = 1'b1;
        bus_write(A_OPA, 32'd3, "rmul_opa");
        bus_write(A_OPB, 32'd5, "rmul_opb");
        bus_write(A_CTRL, 32'd8, "rmul_ctrl");
        idle(9);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        bus_read(A_STAT, st(0, 0, 0, 0), "rmul_status");
        bus_read(A_RLO, 32'd0, "rmul_reslo");
        bus_read(A_RHI, 32'd0, "rmul_reshi");
        check("rmul_irq", {31'd0, irq}, 32'd0);

        // Pass-through after reset, plus LED mapping
        bus_write(A_OPA, 32'd7, "pass_opa");
        bus_write(A_CTRL, 32'd2, "pass_ctrl");
        bus_read(A_STAT, st(1, 0, 0, 0), "pass_status_e1");
        bus_read(A_RLO, 32'd7, "pass_reslo");
        check("pass_leds", {20'd0, leds}, 32'h277);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
